// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable 16x-oversampled UART receiver.
// 5-8 data bits, none/even/odd parity, 1/2 stops, valid/ready output.
module uart_rx_cfg #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_len,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_perr,
  output logic             m_ferr,
  output logic             m_brk,
  output logic             start_pulse,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [DIV_W-1:0]       r_tcnt;
  logic [3:0]             r_sc;
  logic [2:0]             r_idx;
  logic                   r_s7;
  logic                   r_s8;
  logic                   r_armed;
  logic [1:0]             r_len;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic                   r_stop2;
  logic [7:0]             r_shift;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_allz;
  logic                   r_valid;
  logic [7:0]             r_data;
  logic                   r_m_perr;
  logic                   r_m_ferr;
  logic                   r_m_brk;
  logic                   r_start_pulse;
  logic                   r_overrun;

  logic w_rx;
  logic w_tick;
  logic w_s9;
  logic w_end;
  logic w_maj;
  logic w_start;
  logic w_last;
  logic w_done;
  logic w_ferr_fin;
  logic w_brk_fin;
  logic w_pexp;

  assign w_rx    = r_sync[SYNC_STAGES-1];
  assign w_tick  = (r_tcnt >= baud_div);
  assign w_s9    = w_tick && (r_sc == 4'd9);
  assign w_end   = w_tick && (r_sc == 4'd15);
  assign w_maj   = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);
  assign w_start = (r_state == S_IDLE) && r_armed && !w_rx;
  assign w_last  = (r_idx == ({1'b0, r_len} + 3'd4));
  assign w_pexp  = (^r_shift) ^ r_par_odd;

  // Completion happens on the last stop sample, not at the end of the bit.
  assign w_done = w_s9 &&
                  (((r_state == S_STOP1) && !r_stop2) ||
                   (r_state == S_STOP2));

  assign w_ferr_fin = ((r_state == S_STOP2) ? r_ferr : 1'b0) | !w_maj;
  assign w_brk_fin  = r_allz & !w_maj;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_START;
      end
      S_START: begin
        if (w_s9 && w_maj) w_next = S_IDLE;
        else if (w_end)    w_next = S_DATA;
      end
      S_DATA: begin
        if (w_end && w_last)
          w_next = r_par_en ? S_PARITY : S_STOP1;
      end
      S_PARITY: begin
        if (w_end) w_next = S_STOP1;
      end
      S_STOP1: begin
        if (w_s9 && !r_stop2) w_next = S_IDLE;
        else if (w_end)       w_next = S_STOP2;
      end
      S_STOP2: begin
        if (w_s9) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '1;
      r_tcnt  <= '0;
      r_sc    <= '0;
      r_s7    <= 1'b1;
      r_s8    <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      if (w_start || w_tick) r_tcnt <= '0;
      else                   r_tcnt <= r_tcnt + 1'b1;
      if (w_start || (r_state == S_IDLE)) r_sc <= '0;
      else if (w_tick)                    r_sc <= r_sc + 4'd1;
      if (w_tick && (r_sc == 4'd7)) r_s7 <= w_rx;
      if (w_tick && (r_sc == 4'd8)) r_s8 <= w_rx;
      // A line held low must go high before another start is accepted.
      if (w_start)                             r_armed <= 1'b0;
      else if ((r_state == S_IDLE) && w_rx)    r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_stop2   <= 1'b0;
      r_shift   <= '0;
      r_idx     <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_allz    <= 1'b0;
    end else if (w_start) begin
      r_len     <= data_len;
      r_par_en  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
      r_par_odd <= (parity_mode == 2'd2);
      r_stop2   <= stop2;
      r_shift   <= '0;
      r_idx     <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_allz    <= 1'b1;
    end else begin
      if (w_s9) begin
        unique case (1'b1)
          (r_state == S_DATA): begin
            r_shift[r_idx] <= w_maj;
            r_allz         <= r_allz & !w_maj;
          end
          (r_state == S_PARITY): begin
            r_perr <= (w_maj != w_pexp);
            r_allz <= r_allz & !w_maj;
          end
          (r_state == S_STOP1): begin
            r_ferr <= !w_maj;
            r_allz <= r_allz & !w_maj;
          end
          (r_state == S_STOP2): begin
            r_ferr <= r_ferr | !w_maj;
            r_allz <= r_allz & !w_maj;
          end
          default: ;
        endcase
      end
      if ((r_state == S_DATA) && w_end) r_idx <= r_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_data        <= '0;
      r_m_perr      <= 1'b0;
      r_m_ferr      <= 1'b0;
      r_m_brk       <= 1'b0;
      r_start_pulse <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_start_pulse <= (r_state == S_START) && w_s9 && !w_maj;
      r_overrun     <= 1'b0;
      if (w_done) begin
        if (!r_valid || m_ready) begin
          r_valid  <= 1'b1;
          r_data   <= r_shift;
          r_m_perr <= r_perr;
          r_m_ferr <= w_ferr_fin;
          r_m_brk  <= w_brk_fin;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_valid     = r_valid;
  assign m_data      = r_data;
  assign m_perr      = r_m_perr;
  assign m_ferr      = r_m_ferr;
  assign m_brk       = r_m_brk;
  assign start_pulse = r_start_pulse;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg.
// Serial frames are built in the bench; outputs logged on negedge.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] baud_div;
  logic [1:0]  data_len;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_perr;
  logic        m_ferr;
  logic        m_brk;
  logic        start_pulse;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int bit_clks = 16;
  int sp_cnt = 0;
  int ov_cnt = 0;
  logic [10:0] rxq[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .baud_div(baud_div), .data_len(data_len),
    .parity_mode(parity_mode), .stop2(stop2),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_perr(m_perr),
    .m_ferr(m_ferr), .m_brk(m_brk),
    .start_pulse(start_pulse), .overrun(overrun)
  );

  // entry = {brk, ferr, perr, data}
  always @(negedge clk) begin
    if (m_valid && m_ready)
      rxq.push_back({m_brk, m_ferr, m_perr, m_data});
    if (start_pulse) sp_cnt++;
    if (overrun) ov_cnt++;
  end

  function automatic logic [10:0] entry(input int i);
    if (i < rxq.size()) return rxq[i];
    return 11'h7ff;
  endfunction

  task automatic set_cfg(input int b, input logic [1:0] len,
                         input logic [1:0] pm, input logic s2);
    baud_div    = b[15:0];
    bit_clks    = 16 * (b + 1);
    data_len    = len;
    parity_mode = pm;
    stop2       = s2;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (bit_clks) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int nb);
    repeat (nb) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n,
                            input bit has_par, input logic pbit,
                            input int nstop, input logic st2);
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(1'b1);
    if (nstop == 2) drive_bit(st2);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; m_ready = 1'b0;
    set_cfg(26, 2'd3, 2'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b want 0", m_valid);
    end
    tests++;
    if (m_data !== 8'h00) begin
      fails++; $display("FAIL reset_data got %h want 00", m_data);
    end
    tests++;
    if ({m_perr, m_ferr, m_brk} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b want 000", {m_perr, m_ferr, m_brk});
    end
    tests++;
    if ({start_pulse, overrun} !== 2'b00) begin
      fails++;
      $display("FAIL reset_pulses got %b want 00", {start_pulse, overrun});
    end
  endtask

  task automatic test_8n1;
    int base, sp0;
    logic [10:0] e;
    m_ready = 1'b1;
    set_cfg(26, 2'd3, 2'd0, 1'b0);
    idle(1);
    base = rxq.size(); sp0 = sp_cnt;
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    e = entry(base);
    tests++;
    if (rxq.size() - base !== 1) begin
      fails++; $display("FAIL 8n1_count got %0d want 1", rxq.size() - base);
    end
    tests++;
    if (e[7:0] !== 8'hA5) begin
      fails++; $display("FAIL 8n1_data got %h want a5", e[7:0]);
    end
    tests++;
    if (e[10:8] !== 3'b000) begin
      fails++; $display("FAIL 8n1_flags got %b want 000", e[10:8]);
    end
    tests++;
    if (sp_cnt - sp0 !== 1) begin
      fails++; $display("FAIL 8n1_start got %0d want 1", sp_cnt - sp0);
    end
  endtask

  task automatic test_parity;
    int base;
    logic [10:0] e;
    set_cfg(3, 2'd2, 2'd1, 1'b0);
    idle(1);
    base = rxq.size();
    send_frame(8'h35, 7, 1, 1'b1, 1, 1'b1);
    idle(2);
    e = entry(base);
    tests++;
    if (e[7:0] !== 8'h35) begin
      fails++; $display("FAIL par_bad_data got %h want 35", e[7:0]);
    end
    tests++;
    if (e[8] !== 1'b1) begin
      fails++; $display("FAIL par_bad_perr got %b want 1", e[8]);
    end
    send_frame(8'h35, 7, 1, 1'b0, 1, 1'b1);
    idle(2);
    e = entry(base + 1);
    tests++;
    if (e[10:0] !== {3'b000, 8'h35}) begin
      fails++; $display("FAIL par_ok got %h want 035", e);
    end
  endtask

  task automatic test_baud0_odd;
    int base;
    logic [10:0] e;
    set_cfg(0, 2'd1, 2'd2, 1'b1);
    idle(1);
    base = rxq.size();
    send_frame(8'h2B, 6, 1, 1'b1, 2, 1'b1);
    idle(2);
    e = entry(base);
    tests++;
    if (e[10:0] !== {3'b000, 8'h2B}) begin
      fails++; $display("FAIL odd_ok got %h want 02b", e);
    end
    send_frame(8'h2B, 6, 1, 1'b0, 2, 1'b1);
    idle(2);
    e = entry(base + 1);
    tests++;
    if (e[10:0] !== {3'b001, 8'h2B}) begin
      fails++; $display("FAIL odd_bad got %h want 12b", e);
    end
  endtask

  task automatic test_framing;
    int base;
    logic [10:0] e;
    set_cfg(3, 2'd3, 2'd0, 1'b1);
    idle(1);
    base = rxq.size();
    send_frame(8'h3C, 8, 0, 1'b0, 2, 1'b0);
    idle(2);
    e = entry(base);
    tests++;
    if (e[7:0] !== 8'h3C) begin
      fails++; $display("FAIL fr2_data got %h want 3c", e[7:0]);
    end
    tests++;
    if (e[10:8] !== 3'b010) begin
      fails++; $display("FAIL fr2_flags got %b want 010", e[10:8]);
    end
    stop2 = 1'b0;
    base = rxq.size();
    send_frame(8'h3C, 8, 0, 1'b0, 2, 1'b0);
    idle(12);
    e = entry(base);
    tests++;
    if (e[10:0] !== {3'b000, 8'h3C}) begin
      fails++; $display("FAIL fr1_ok got %h want 03c", e);
    end
  endtask

  task automatic test_cfg_latch;
    int base;
    logic [10:0] e;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    idle(1);
    base = rxq.size();
    fork
      send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1);
      begin
        repeat (bit_clks * 3) @(posedge clk);
        #1 data_len = 2'd0; parity_mode = 2'd1; stop2 = 1'b1;
      end
    join
    idle(2);
    e = entry(base);
    tests++;
    if (rxq.size() - base !== 1) begin
      fails++; $display("FAIL latch_count got %0d want 1", rxq.size() - base);
    end
    tests++;
    if (e[10:0] !== {3'b000, 8'h5A}) begin
      fails++; $display("FAIL latch_frame got %h want 05a", e);
    end
  endtask

  task automatic test_glitch;
    int base, sp0;
    logic [10:0] e;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    idle(1);
    base = rxq.size(); sp0 = sp_cnt;
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    idle(2);
    tests++;
    if (sp_cnt - sp0 !== 0) begin
      fails++; $display("FAIL glitch_start got %0d want 0", sp_cnt - sp0);
    end
    tests++;
    if (rxq.size() - base !== 0) begin
      fails++; $display("FAIL glitch_frames got %0d want 0", rxq.size() - base);
    end
    send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    e = entry(base);
    tests++;
    if (e[10:0] !== {3'b000, 8'h5A}) begin
      fails++; $display("FAIL glitch_next got %h want 05a", e);
    end
    tests++;
    if (sp_cnt - sp0 !== 1) begin
      fails++; $display("FAIL glitch_next_start got %0d want 1", sp_cnt - sp0);
    end
  endtask

  task automatic test_break;
    int base;
    logic [10:0] e;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    idle(1);
    base = rxq.size();
    repeat (12) drive_bit(1'b0);
    idle(2);
    e = entry(base);
    tests++;
    if (rxq.size() - base !== 1) begin
      fails++; $display("FAIL brk_count got %0d want 1", rxq.size() - base);
    end
    tests++;
    if (e[7:0] !== 8'h00) begin
      fails++; $display("FAIL brk_data got %h want 00", e[7:0]);
    end
    tests++;
    if (e[10:8] !== 3'b110) begin
      fails++; $display("FAIL brk_flags got %b want 110", e[10:8]);
    end
    send_frame(8'hC3, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    e = entry(base + 1);
    tests++;
    if (e[10:0] !== {3'b000, 8'hC3}) begin
      fails++; $display("FAIL brk_next got %h want 0c3", e);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    idle(1);
    base = rxq.size();
    send_frame(8'h0F, 8, 0, 1'b0, 1, 1'b1);
    send_frame(8'hF0, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    tests++;
    if (rxq.size() - base !== 2) begin
      fails++; $display("FAIL b2b_count got %0d want 2", rxq.size() - base);
    end
    tests++;
    if ({entry(base), entry(base + 1)} !== {11'h00F, 11'h0F0}) begin
      fails++;
      $display("FAIL b2b_data got %h %h want 00f 0f0", entry(base), entry(base + 1));
    end
  endtask

  task automatic test_overrun;
    int base, ov0;
    logic [10:0] e;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    m_ready = 1'b0;
    idle(1);
    base = rxq.size(); ov0 = ov_cnt;
    send_frame(8'h11, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    tests++;
    if ({m_valid, m_data} !== {1'b1, 8'h11}) begin
      fails++; $display("FAIL ovr_first got %b/%h want 1/11", m_valid, m_data);
    end
    send_frame(8'h22, 8, 0, 1'b0, 1, 1'b1);
    idle(2);
    tests++;
    if (ov_cnt - ov0 !== 1) begin
      fails++; $display("FAIL ovr_pulse got %0d want 1", ov_cnt - ov0);
    end
    tests++;
    if ({m_valid, m_data} !== {1'b1, 8'h11}) begin
      fails++; $display("FAIL ovr_hold got %b/%h want 1/11", m_valid, m_data);
    end
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = entry(base);
    tests++;
    if (rxq.size() - base !== 1) begin
      fails++; $display("FAIL ovr_count got %0d want 1", rxq.size() - base);
    end
    tests++;
    if (e[10:0] !== {3'b000, 8'h11}) begin
      fails++; $display("FAIL ovr_xfer got %h want 011", e);
    end
    tests++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL ovr_clear got %b want 0", m_valid);
    end
  endtask

  task automatic test_reset_midframe;
    int base;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    m_ready = 1'b0;
    idle(1);
    send_frame(8'h44, 8, 0, 1'b0, 1, 1'b1);
    idle(1);
    base = rxq.size();
    tests++;
    if (m_valid !== 1'b1) begin
      fails++; $display("FAIL rstm_pending got %b want 1", m_valid);
    end
    fork
      send_frame(8'hFF, 8, 0, 1'b0, 1, 1'b1);
      begin
        repeat (bit_clks * 4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++;
        if (m_valid !== 1'b0) begin
          fails++; $display("FAIL rstm_valid got %b want 0", m_valid);
        end
      end
    join
    idle(3);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL rstm_noframe got %b want 0", m_valid);
    end
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (rxq.size() - base !== 0) begin
      fails++; $display("FAIL rstm_count got %0d want 0", rxq.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_baud0_odd();
    test_framing();
    test_cfg_latch();
    test_glitch();
    test_break();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL watchdog got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
